// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM state encoding and op-class helper for mc_alu.
// Optional feature macro: MC_ALU_DIV_EN (adds DIVU/REMU as multi-cycle ops).
package alu_pkg;

    localparam int unsigned OP_ADD   = 32'h00;
    localparam int unsigned OP_SUB   = 32'h01;
    localparam int unsigned OP_MUL   = 32'h02;
    localparam int unsigned OP_AND   = 32'h03;
    localparam int unsigned OP_OR    = 32'h04;
    localparam int unsigned OP_XOR   = 32'h05;
    localparam int unsigned OP_NOT   = 32'h06;
    // Address-calculation aliases used by load/store/branch instructions
    localparam int unsigned OP_ADD_A = 32'h0E;
    localparam int unsigned OP_ADD_B = 32'h0F;
    localparam int unsigned OP_SUB_A = 32'h10;
    localparam int unsigned OP_DIVU  = 32'h11;
    localparam int unsigned OP_REMU  = 32'h12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Everything that is not routed through the iterative unit finishes in one
    // cycle, including unsupported opcodes.
    function automatic logic is_single_cycle(input int unsigned op);
`ifdef MC_ALU_DIV_EN
        return !(op == OP_MUL || op == OP_DIVU || op == OP_REMU);
`else
        return op != OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/mc_alu_seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiplier, one step per cycle.
// With MC_ALU_DIV_EN defined it also performs restoring division on the same
// 2*WIDTH accumulator (hi = remainder, lo = quotient when done).
// done is asserted during the final step; prod is then the completed result.
module seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef MC_ALU_DIV_EN
    input  logic                 div,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    logic                 busy;
    logic [CNTW-1:0]      cnt;
    logic [WIDTH-1:0]     m_q;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       msum;
    logic [2*WIDTH-1:0]   acc_nxt;
`ifdef MC_ALU_DIV_EN
    logic                 div_q;
    logic [WIDTH:0]       trial;
    logic                 ge;
    logic [WIDTH-1:0]     rem_n;
`endif

    // One iteration: conditional add of the multiplicand then shift right,
    // or a restoring subtract-and-shift-left when dividing.
    always_comb begin
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
        acc_nxt = {msum, acc[WIDTH-1:1]};
`ifdef MC_ALU_DIV_EN
        trial = acc[2*WIDTH-1:WIDTH-1];
        ge    = trial >= {1'b0, m_q};
        rem_n = ge ? WIDTH'(trial - {1'b0, m_q}) : trial[WIDTH-1:0];
        if (div_q) begin
            acc_nxt = {rem_n, acc[WIDTH-2:0], ge};
        end
`endif
    end

    assign done = busy && (cnt == CNTW'(WIDTH - 1));
    assign prod = acc_nxt;

    // Iteration control: WIDTH steps after start, then idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // Accumulator and step operand load on start, advance while busy.
    always_ff @(posedge clk) begin
        if (start) begin
`ifdef MC_ALU_DIV_EN
            div_q <= div;
            m_q   <= div ? b : a;
            acc   <= {{WIDTH{1'b0}}, (div ? a : b)};
`else
            m_q   <= a;
            acc   <= {{WIDTH{1'b0}}, b};
`endif
        end else if (busy) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with registered valid/ready on both sides.
// Logic/add/sub complete in one cycle; MUL (and DIVU/REMU when the macro
// MC_ALU_DIV_EN is defined) run through the iterative seq_muldiv unit.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 6,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] opnd1,
    input  logic [WIDTH-1:0] opnd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             overflow,
    output logic             illegal_op
);

    state_t               state;
    int unsigned          op_w;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_ov;
    logic                 sc_ill;
    logic                 start;
    logic                 md_done;
    logic [2*WIDTH-1:0]   md_prod;
    logic [WIDTH-1:0]     md_res;
    logic                 md_ov;
`ifdef MC_ALU_DIV_EN
    logic [OPW-1:0]       op_q;
    logic                 divz_q;
    int unsigned          opq_w;
    logic                 is_div;

    assign opq_w  = 32'(op_q);
    assign is_div = (op_w == OP_DIVU) || (op_w == OP_REMU);
`endif

    assign op_w  = 32'(opcode);
    assign start = (state == IDLE) && in_valid && in_ready && !is_single_cycle(op_w);

    // Single-cycle datapath, evaluated on the live operands at the accept edge.
    always_comb begin
        sum_w  = {1'b0, opnd1} + {1'b0, opnd2};
        diff_w = {1'b0, opnd1} - {1'b0, opnd2};
        sc_res = '0;
        sc_ov  = 1'b0;
        sc_ill = 1'b0;
        case (op_w)
            OP_ADD, OP_ADD_A, OP_ADD_B: begin
                sc_res = sum_w[WIDTH-1:0];
                sc_ov  = sum_w[WIDTH];
            end
            OP_SUB, OP_SUB_A: begin
                sc_res = diff_w[WIDTH-1:0];
                sc_ov  = diff_w[WIDTH];
            end
            OP_AND:  sc_res = opnd1 & opnd2;
            OP_OR:   sc_res = opnd1 | opnd2;
            OP_XOR:  sc_res = opnd1 ^ opnd2;
            OP_NOT:  sc_res = ~opnd1;
            default: sc_ill = 1'b1;
        endcase
    end

    seq_muldiv #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef MC_ALU_DIV_EN
        .div   (is_div),
`endif
        .a     (opnd1),
        .b     (opnd2),
        .done  (md_done),
        .prod  (md_prod)
    );

`ifdef MC_ALU_DIV_EN
    // Opcode and divide-by-zero marker held for the whole iterative run.
    always_ff @(posedge clk) begin
        if (start) begin
            op_q   <= opcode;
            divz_q <= (opnd2 == '0);
        end
    end
`endif

    // Select the final result and overflow of the iterative unit.
    always_comb begin
        md_res = md_prod[WIDTH-1:0];
        md_ov  = |md_prod[2*WIDTH-1:WIDTH];
`ifdef MC_ALU_DIV_EN
        if (opq_w == OP_DIVU) begin
            md_ov = divz_q;
        end else if (opq_w == OP_REMU) begin
            md_res = md_prod[2*WIDTH-1:WIDTH];
            md_ov  = divz_q;
        end
`endif
    end

    // Control FSM with handshake and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out        <= '0;
            zero_flag  <= 1'b1;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_single_cycle(op_w)) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out        <= sc_res;
                            zero_flag  <= (sc_res == '0);
                            overflow   <= sc_ov;
                            illegal_op <= sc_ill;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out        <= md_res;
                        zero_flag  <= (md_res == '0);
                        overflow   <= md_ov;
                        illegal_op <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
